div_err_accumulator: RTL and testbench

DIV_ERR_ACCUMULATOR -- requirements
Module: div_err_accumulator

---
 rtl/div_eval_pkg.sv | 17 +
 rtl/div_err_lane.sv | 61 ++++++
 rtl/div_err_accumulator.sv | 150 +++++++++++++++
 tb/tb_div_err_accumulator.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_eval_pkg.sv
// Shared definitions for the divider-error evaluation slice.
// Holds default widths and the run-control state encoding used by
// div_err_accumulator.
package div_eval_pkg;

  localparam int unsigned W_DEF     = 8;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned ACC_W_DEF = 2 * W_DEF + CNT_W_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/div_err_lane.sv
// One error lane: registers |a-b| for each offered sample (stage 1) and
// adds its square into a running sum on the following cycle (stage 2).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   clr          clear the running sum (start of a new run)
//   load         sample transfer this cycle; captures |a-b|
//   a, b         operands whose absolute difference is measured
//   diff         registered |a-b| (stage 1 data)
//   diff_valid   stage 1 holds a sample
//   acc          running sum of squared differences
//   acc_valid    stage 2 absorbed a sample on the previous edge
module div_err_lane #(
  parameter int unsigned W     = 8,
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [W-1:0]     diff,
  output logic             diff_valid,
  output logic [ACC_W-1:0] acc,
  output logic             acc_valid
);

  logic [W-1:0]   abs_diff;
  logic [2*W-1:0] diff_ext;
  logic [2*W-1:0] diff_sq;

  always_comb begin
    abs_diff = (a >= b) ? (a - b) : (b - a);
  end

  always_comb begin
    diff_ext = {{W{1'b0}}, diff};
    diff_sq  = diff_ext * diff_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      diff       <= '0;
      diff_valid <= 1'b0;
      acc        <= '0;
      acc_valid  <= 1'b0;
    end else begin
      diff_valid <= load;
      if (load) begin
        diff <= abs_diff;
      end
      acc_valid <= diff_valid;
      if (clr) begin
        acc <= '0;
      end else if (diff_valid) begin
        acc <= acc + {{(ACC_W-2*W){1'b0}}, diff_sq};
      end
    end
  end

endmodule

// File: rtl/div_err_accumulator.sv
// Accumulates error statistics of an approximate divider against an exact
// reference over a run of num_samples samples.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, num_samples       run request (IDLE only) and its sample count
//   in_valid, in_ready       sample handshake
//   q_apx, r_apx             approximate quotient / remainder
//   q_ref, r_ref             exact quotient / remainder
//   busy                     run in progress (any state but IDLE)
//   done                     one-cycle pulse when results are final
//   sse_q, sse_r             sums of squared quotient / remainder errors
//   max_err_q                largest quotient error this run
//   sample_cnt               samples accumulated this run
module div_err_accumulator
  import div_eval_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned ACC_W = 2 * W + CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     q_apx,
  input  logic [W-1:0]     r_apx,
  input  logic [W-1:0]     q_ref,
  input  logic [W-1:0]     r_ref,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sse_q,
  output logic [ACC_W-1:0] sse_r,
  output logic [W-1:0]     max_err_q,
  output logic [CNT_W-1:0] sample_cnt
);

  state_t state, state_next;

  logic [CNT_W-1:0] n_cap;
  logic [CNT_W-1:0] acc_cnt;
  logic             start_acc;
  logic             xfer;
  logic             last_xfer;

  logic [W-1:0] q_diff, r_diff;
  logic         q_dv, r_dv, q_av, r_av;
  logic         pipe_busy;
  logic         unused_r_diff;

  assign start_acc = (state == IDLE) && start;
  assign in_ready  = (state == ACCUM) && (acc_cnt < n_cap);
  assign xfer      = in_valid && in_ready;
  assign last_xfer = xfer && ((acc_cnt + CNT_W'(1)) == n_cap);
  assign pipe_busy = q_dv | r_dv | q_av | r_av;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // The remainder lane's registered difference has no consumer here.
  assign unused_r_diff = ^r_diff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (num_samples == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (last_xfer) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (!pipe_busy) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_cap      <= '0;
      acc_cnt    <= '0;
      max_err_q  <= '0;
      sample_cnt <= '0;
    end else if (start_acc) begin
      n_cap      <= num_samples;
      acc_cnt    <= '0;
      max_err_q  <= '0;
      sample_cnt <= '0;
    end else begin
      if (xfer) begin
        acc_cnt <= acc_cnt + CNT_W'(1);
      end
      // Stage 2: the max tracker and sample counter advance in lockstep
      // with the lanes' square-accumulate step.
      if (q_dv) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
        if (q_diff > max_err_q) begin
          max_err_q <= q_diff;
        end
      end
    end
  end

  div_err_lane #(.W(W), .ACC_W(ACC_W)) u_lane_q (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_acc),
    .load       (xfer),
    .a          (q_apx),
    .b          (q_ref),
    .diff       (q_diff),
    .diff_valid (q_dv),
    .acc        (sse_q),
    .acc_valid  (q_av)
  );

  div_err_lane #(.W(W), .ACC_W(ACC_W)) u_lane_r (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_acc),
    .load       (xfer),
    .a          (r_apx),
    .b          (r_ref),
    .diff       (r_diff),
    .diff_valid (r_dv),
    .acc        (sse_r),
    .acc_valid  (r_av)
  );

endmodule

// File: tb/tb_div_err_accumulator.sv
module tb_div_err_accumulator;

  localparam int W     = 8;
  localparam int CNT_W = 16;
  localparam int ACC_W = 2 * W + CNT_W;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     q_apx, r_apx, q_ref, r_ref;
  logic             busy, done;
  logic [ACC_W-1:0] sse_q, sse_r;
  logic [W-1:0]     max_err_q;
  logic [CNT_W-1:0] sample_cnt;

  div_err_accumulator #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .q_apx       (q_apx),
    .r_apx       (r_apx),
    .q_ref       (q_ref),
    .r_ref       (r_ref),
    .busy        (busy),
    .done        (done),
    .sse_q       (sse_q),
    .sse_r       (sse_r),
    .max_err_q   (max_err_q),
    .sample_cnt  (sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint unsigned sse_q;
    longint unsigned sse_r;
    int              max_q;
    int              cnt;
    int              done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model of the run in progress
  longint unsigned m_sq, m_sr;
  int              m_max, m_cnt, run_n;

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Monitor: pops an expectation on every done pulse, checks the cycle after.
  logic prev_done = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (prev_done) begin
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("hold_sse_q", sse_q, last_e.sse_q);
        check("hold_max_err_q", max_err_q, last_e.max_q);
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          last_e = sb.pop_front();
          check("sse_q", sse_q, last_e.sse_q);
          check("sse_r", sse_r, last_e.sse_r);
          check("max_err_q", max_err_q, last_e.max_q);
          check("sample_cnt", sample_cnt, last_e.cnt);
          check("done_latency", cyc, last_e.done_cyc);
        end
      end
      prev_done = done;
    end
  end

  // Tasks begin and end at posedge+1.
  task automatic start_run(input int n);
    start       = 1'b1;
    num_samples = CNT_W'(n);
    m_sq = 0; m_sr = 0; m_max = 0; m_cnt = 0; run_n = n;
    @(negedge clk);
    if (n == 0) sb.push_back('{0, 0, 0, 0, cyc + 1});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int qa, input int ra, input int qr, input int rr,
                      input int gap);
    bit accepted = 0;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    q_apx = qa[W-1:0]; r_apx = ra[W-1:0];
    q_ref = qr[W-1:0]; r_ref = rr[W-1:0];
    for (int t = 0; t < 50 && !accepted; t++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1;
        m_sq += longint'(absdiff(qa, qr) * absdiff(qa, qr));
        m_sr += longint'(absdiff(ra, rr) * absdiff(ra, rr));
        if (absdiff(qa, qr) > m_max) m_max = absdiff(qa, qr);
        m_cnt++;
        if (m_cnt == run_n) sb.push_back('{m_sq, m_sr, m_max, m_cnt, cyc + 4});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("sample_accepted", accepted, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) ok = 1;
    end
    check("run_completed", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_sse_q"}, sse_q, 0);
    check({tag, "_sse_r"}, sse_r, 0);
    check({tag, "_max_err_q"}, max_err_q, 0);
    check({tag, "_sample_cnt"}, sample_cnt, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
    q_apx = '0; r_apx = '0; q_ref = '0; r_ref = '0;
    m_sq = 0; m_sr = 0; m_max = 0; m_cnt = 0; run_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Exact divider: no error at all
    start_run(4);
    for (int i = 0; i < 4; i++) send(i * 17, i * 5, i * 17, i * 5, 0);
    wait_idle();

    // Single worst-case quotient error, remainder diff 3
    start_run(1);
    send(8'h00, 10, 8'hFF, 7, 0);
    wait_idle();

    // Diffs 1,2,3 with 2-cycle in_valid gaps
    start_run(3);
    send(11, 4, 10, 4, 2);
    send(20, 4, 22, 4, 2);
    send(3, 4, 6, 4, 2);
    @(negedge clk);
    check("in_ready_after_last", in_ready, 0);
    @(posedge clk); #1;
    wait_idle();

    // Zero-sample run
    start_run(0);
    @(negedge clk);
    check("zero_run_in_ready", in_ready, 0);
    @(posedge clk); #1;
    wait_idle();

    // Reset mid-run after 2 of 5 samples
    start_run(5);
    send(50, 9, 40, 1, 0);
    send(7, 2, 1, 3, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("midrun_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start_run(1);
    send(12, 0, 10, 0, 0);
    wait_idle();

    // Start pulsed during ACCUM with a different count is ignored
    start_run(5);
    send(1, 2, 3, 4, 0);
    send(9, 9, 0, 0, 1);
    start = 1'b1;
    num_samples = CNT_W'(9);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_ignored_start", busy, 1);
    @(posedge clk); #1;
    send(100, 1, 90, 2, 0);
    send(5, 6, 5, 6, 2);
    send(255, 255, 0, 0, 0);
    wait_idle();

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(1, 10));
      start_run(n);
      for (int i = 0; i < n; i++)
        send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 2)));
      wait_idle();
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
